// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART RX oversampling path.
package uart_rx_pkg;

  localparam logic [5:0] PRESC_8  = 6'd8;
  localparam logic [5:0] PRESC_16 = 6'd16;
  localparam logic [5:0] PRESC_32 = 6'd32;
  localparam int FRAME_BITS_DEF   = 11;

  // Unsupported ratios fall back to x8 so the counters always have a sane wrap point.
  function automatic logic [5:0] eff_prescale(input logic [5:0] prescale);
    case (prescale)
      PRESC_16: return PRESC_16;
      PRESC_32: return PRESC_32;
      default:  return PRESC_8;
    endcase
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Edge-within-bit and bit-within-frame counters for the RX sampler.
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sampler_en,
  input  logic [5:0]           eff_p,
  output logic [5:0]           edge_cnt,
  output logic [BIT_CNT_W-1:0] bit_cnt
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

  logic bit_end;

  // Using >= lets a mid-frame ratio change wrap instead of running past P-1.
  assign bit_end = (edge_cnt >= (eff_p - 6'd1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!sampler_en) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (bit_end) begin
      edge_cnt <= '0;
      bit_cnt  <= (bit_cnt >= LAST_BIT) ? '0 : bit_cnt + BIT_CNT_W'(1);
    end else begin
      edge_cnt <= edge_cnt + 6'd1;
    end
  end

endmodule

// File: rtl/uart_rx_bit_sampler.sv
// UART RX bit sampler: 3-point mid-bit majority vote over an oversampled line.
// Optional RX_SYNC_EN adds a 2-flop input synchronizer ahead of the sample points.
module uart_rx_bit_sampler
  import uart_rx_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic [5:0]           prescale,
  input  logic                 sampler_en,
  output logic [5:0]           edge_cnt,
  output logic [BIT_CNT_W-1:0] bit_cnt,
  output logic                 sampled_bit,
  output logic                 sample_valid
);

  logic [5:0] eff_p;
  logic [5:0] mid;
  logic       rx_s;
  logic       s0;
  logic       s1;

  assign eff_p = eff_prescale(prescale);
  assign mid   = {1'b0, eff_p[5:1]};

`ifdef RX_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst) sync_q <= 2'b11;
    else      sync_q <= {sync_q[0], rx_in};
  end

  assign rx_s = sync_q[1];
`else
  assign rx_s = rx_in;
`endif

  uart_rx_edge_bit_counter #(
    .FRAME_BITS(FRAME_BITS),
    .BIT_CNT_W (BIT_CNT_W)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .sampler_en(sampler_en),
    .eff_p     (eff_p),
    .edge_cnt  (edge_cnt),
    .bit_cnt   (bit_cnt)
  );

  // Samples at M-2 and M-1 are held; the vote at M uses the live third sample.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s0           <= 1'b1;
      s1           <= 1'b1;
      sampled_bit  <= 1'b1;
      sample_valid <= 1'b0;
    end else if (!sampler_en) begin
      s0           <= 1'b1;
      s1           <= 1'b1;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (edge_cnt == (mid - 6'd2)) s0 <= rx_s;
      if (edge_cnt == (mid - 6'd1)) s1 <= rx_s;
      if (edge_cnt == mid) begin
        sampled_bit  <= maj3(s0, s1, rx_s);
        sample_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_bit_sampler.sv
// Directed, table-driven bench for uart_rx_bit_sampler.
module tb_uart_rx_bit_sampler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       sampler_en = 1'b0;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sampled_bit;
  logic       sample_valid;

  int checks = 0;
  int errors = 0;

`ifdef RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    logic       r;
    logic       e;
    logic       x;
    logic [5:0] ps;
    int         ec;
    int         bc;
    logic       sb;
    logic       sv;
  } vec_t;

  vec_t vecs[24];

  always #5 clk = ~clk;

  uart_rx_bit_sampler #(
    .FRAME_BITS(11),
    .BIT_CNT_W (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .prescale    (prescale),
    .sampler_en  (sampler_en),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .sampled_bit (sampled_bit),
    .sample_valid(sample_valid)
  );

  function automatic vec_t mk(input logic r, input logic e, input logic x, input int ps,
                              input int ec, input int bc, input logic sb, input logic sv);
    vec_t v;
    v.r = r; v.e = e; v.x = x; v.ps = 6'(ps);
    v.ec = ec; v.bc = bc; v.sb = sb; v.sv = sv;
    return v;
  endfunction

  task automatic applyStimulus(input logic r, input logic e, input logic x, input logic [5:0] p);
    rst        = r;
    sampler_en = e;
    rx_in      = x;
    prescale   = p;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int eec, input int ebc,
                             input logic esb, input logic esv);
    checks++;
    if (edge_cnt !== 6'(eec) || bit_cnt !== 4'(ebc) ||
        sampled_bit !== esb || sample_valid !== esv) begin
      errors++;
      $display("[TB] FAIL %s: got ec=%0d bc=%0d sb=%b sv=%b, expected ec=%0d bc=%0d sb=%b sv=%b",
               name, edge_cnt, bit_cnt, sampled_bit, sample_valid, eec, ebc, esb, esv);
    end
  endtask

  task automatic checkCount(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // One 16x bit with rx high over edges lo..hi (shifted by synchronizer latency).
  task automatic runBit16(input int lo, input int hi, input int bc, input logic exp_sb);
    for (int e = 0; e < 16; e++) begin
      applyStimulus(1'b1, 1'b1, (e >= lo - LAT) && (e <= hi - LAT), 6'd16);
      if (e == 8)  checkOutput("p16_vote", 9, bc, exp_sb, 1'b1);
      if (e == 15) checkOutput("p16_wrap", 0, bc + 1, exp_sb, 1'b0);
    end
  endtask

  initial begin
    int pulses;
    int cnt_bad;
    int seen_last;

    // reset, x8 with rx low, disable, illegal ratio 12 acting as x8, reset mid-frame
    vecs[0]  = mk(0, 0, 1, 8,  0, 0, 1, 0);
    vecs[1]  = mk(1, 1, 0, 8,  1, 0, 1, 0);
    vecs[2]  = mk(1, 1, 0, 8,  2, 0, 1, 0);
    vecs[3]  = mk(1, 1, 0, 8,  3, 0, 1, 0);
    vecs[4]  = mk(1, 1, 0, 8,  4, 0, 1, 0);
    vecs[5]  = mk(1, 1, 0, 8,  5, 0, 0, 1);
    vecs[6]  = mk(1, 1, 0, 8,  6, 0, 0, 0);
    vecs[7]  = mk(1, 1, 0, 8,  7, 0, 0, 0);
    vecs[8]  = mk(1, 1, 0, 8,  0, 1, 0, 0);
    vecs[9]  = mk(1, 1, 0, 8,  1, 1, 0, 0);
    vecs[10] = mk(1, 1, 0, 8,  2, 1, 0, 0);
    vecs[11] = mk(1, 1, 0, 8,  3, 1, 0, 0);
    vecs[12] = mk(1, 1, 0, 8,  4, 1, 0, 0);
    vecs[13] = mk(1, 1, 0, 8,  5, 1, 0, 1);
    vecs[14] = mk(1, 0, 0, 8,  0, 0, 0, 0);
    vecs[15] = mk(1, 1, 1, 12, 1, 0, 0, 0);
    vecs[16] = mk(1, 1, 1, 12, 2, 0, 0, 0);
    vecs[17] = mk(1, 1, 1, 12, 3, 0, 0, 0);
    vecs[18] = mk(1, 1, 1, 12, 4, 0, 0, 0);
    vecs[19] = mk(1, 1, 1, 12, 5, 0, 1, 1);
    vecs[20] = mk(1, 1, 1, 12, 6, 0, 1, 0);
    vecs[21] = mk(1, 1, 1, 12, 7, 0, 1, 0);
    vecs[22] = mk(1, 1, 1, 12, 0, 1, 1, 0);
    vecs[23] = mk(0, 1, 0, 8,  0, 0, 1, 0);

    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i].r, vecs[i].e, vecs[i].x, vecs[i].ps);
      checkOutput($sformatf("vec%0d", i), vecs[i].ec, vecs[i].bc, vecs[i].sb, vecs[i].sv);
    end

    // x16 majority: single-edge glitch loses, two-edge glitch wins
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd16);
    checkOutput("p16_clear", 0, 0, 1'b1, 1'b0);
    runBit16(7, 7, 0, 1'b0);
    runBit16(7, 8, 1, 1'b1);

    // x32 full frame: 352 clocks, 11 pulses, bit_cnt wraps after 10
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd32);
    pulses = 0; cnt_bad = 0; seen_last = 0;
    for (int k = 1; k <= 352; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 6'd32);
      if (edge_cnt !== 6'(k % 32) || bit_cnt !== 4'((k / 32) % 11)) cnt_bad++;
      if (sample_valid === 1'b1) begin
        pulses++;
        if (edge_cnt !== 6'd17) cnt_bad++;
      end
      if (bit_cnt === 4'd10) seen_last = 1;
    end
    checkCount("p32_counter_errs", cnt_bad, 0);
    checkCount("p32_pulses", pulses, 11);
    checkCount("p32_saw_bit10", seen_last, 1);
    checkOutput("p32_wrap", 0, 0, 1'b0, 1'b0);

    // drop enable at edge 3 of bit 4 (x8)
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd8);
    for (int i = 0; i < 35; i++)
      applyStimulus(1'b1, 1'b1, (i / 8) == 4, 6'd8);
    checkOutput("drop_pre", 3, 4, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 6'd8);
    checkOutput("drop_clear", 0, 0, 1'b0, 1'b0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 6'd8);
      if (sample_valid === 1'b1) pulses++;
    end
    checkCount("drop_no_pulse", pulses, 0);
    checkOutput("drop_hold", 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 6'd8);
    checkOutput("restart", 1, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
